seq_tx: RTL

SEQ_TX -- requirements
Module: seq_tx

---
 rtl/seq_pkg.sv | 27 ++
 rtl/seq_tx.sv | 137 +++++++++++++
 2 files changed

// File: rtl/seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seq_pkg                                                         |
// | Desc     : Shared framing definitions for seq_tx and the receive blocks.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_PRE  = 3'd1;
  localparam state_t ST_DATA = 3'd2;
  localparam state_t ST_PAR  = 3'd3;
  localparam state_t ST_GAP  = 3'd4;

  localparam logic [3:0] PREAMBLE = 4'b1011;
  localparam int         PRE_LEN  = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seq_tx                                                          |
// | Desc     : Serial frame transmitter: preamble, MSB-first payload, optional |
// |            even parity (SEQ_TX_PARITY_EN), trailing zero gap.              |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module seq_tx
  import seq_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int GAP_LEN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out,
  output logic              busy,
  output logic              frame_done
);

  // Counter holds the largest per-state index, max(DATA_W, GAP_LEN, 4) - 1.
  localparam int                 c_cnt_w     = $clog2(max3(DATA_W, GAP_LEN, PRE_LEN));
  localparam logic [c_cnt_w-1:0] c_pre_last  = c_cnt_w'(PRE_LEN - 1);
  localparam logic [c_cnt_w-1:0] c_data_last = c_cnt_w'(DATA_W - 1);
  localparam logic [c_cnt_w-1:0] c_gap_last  = c_cnt_w'(GAP_LEN - 1);
  localparam logic [1:0]         c_pre_top   = 2'(PRE_LEN - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [c_cnt_w-1:0]  w_cnt_nxt;
  logic [DATA_W-1:0]   r_shift;
  logic [DATA_W-1:0]   w_shift_nxt;
  logic                r_out;
  logic                w_out_nxt;
  logic                w_hs;
`ifdef SEQ_TX_PARITY_EN
  logic                r_parity;
`endif

  assign in_ready   = (r_state == ST_IDLE);
  assign busy       = (r_state != ST_IDLE);
  assign frame_done = (r_state == ST_GAP) && (r_cnt == c_gap_last);
  assign out        = r_out;
  assign w_hs       = in_valid && in_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + c_cnt_w'(1);
    w_shift_nxt = r_shift;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (w_hs) begin
          w_state_nxt = ST_PRE;
          w_shift_nxt = in_data;
        end
      end
      ST_PRE: begin
        if (r_cnt == c_pre_last) begin
          w_state_nxt = ST_DATA;
          w_cnt_nxt   = '0;
        end
      end
      ST_DATA: begin
        w_shift_nxt = r_shift << 1;
        if (r_cnt == c_data_last) begin
`ifdef SEQ_TX_PARITY_EN
          w_state_nxt = ST_PAR;
`else
          w_state_nxt = ST_GAP;
`endif
          w_cnt_nxt   = '0;
        end
      end
`ifdef SEQ_TX_PARITY_EN
      ST_PAR: begin
        w_state_nxt = ST_GAP;
        w_cnt_nxt   = '0;
      end
`endif
      ST_GAP: begin
        if (r_cnt == c_gap_last) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // The output bit is chosen from the state being entered so that out is a
  // plain register aligned with the state it belongs to.
  always_comb begin
    w_out_nxt = 1'b0;
    case (w_state_nxt)
      ST_PRE:  w_out_nxt = PREAMBLE[c_pre_top - w_cnt_nxt[1:0]];
      ST_DATA: w_out_nxt = w_shift_nxt[DATA_W-1];
`ifdef SEQ_TX_PARITY_EN
      ST_PAR:  w_out_nxt = r_parity;
`endif
      default: w_out_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_out   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
      r_out   <= w_out_nxt;
    end
  end

`ifdef SEQ_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_parity <= 1'b0;
    end else if (w_hs) begin
      r_parity <= ^in_data;
    end
  end
`endif

endmodule
`default_nettype wire
